// File: rtl/systolic_skew_feeder.sv
// Source-side sequencer for a 4x4 systolic multiplier: stores operand matrices A and B
// and replays them as a diagonally skewed left/top edge stream followed by zero flush slots.
module systolic_skew_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int FLUSH      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic                  wr_sel_i,
  input  logic [3:0]            wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  start_i,
  output logic [DATA_WIDTH-1:0] left_o_0,
  output logic [DATA_WIDTH-1:0] left_o_4,
  output logic [DATA_WIDTH-1:0] left_o_8,
  output logic [DATA_WIDTH-1:0] left_o_12,
  output logic [DATA_WIDTH-1:0] up_o_0,
  output logic [DATA_WIDTH-1:0] up_o_1,
  output logic [DATA_WIDTH-1:0] up_o_2,
  output logic [DATA_WIDTH-1:0] up_o_3,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int TW = 5;
  localparam int L  = 7 + FLUSH;
  localparam logic [TW-1:0] LAST = TW'(L - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  state_e state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [TW-1:0] slot_sel;
  logic          emit;

  logic [DATA_WIDTH-1:0] a_q [16];
  logic [DATA_WIDTH-1:0] a_d [16];
  logic [DATA_WIDTH-1:0] b_q [16];
  logic [DATA_WIDTH-1:0] b_d [16];
  logic [DATA_WIDTH-1:0] left_q [4];
  logic [DATA_WIDTH-1:0] left_d [4];
  logic [DATA_WIDTH-1:0] up_q [4];
  logic [DATA_WIDTH-1:0] up_d [4];

  // Sequencing: the matrix write is folded into a_d/b_d so slot 0 sees a same-edge write.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    a_d      = a_q;
    b_d      = b_q;
    slot_sel = '0;
    emit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_en_i) begin
          if (wr_sel_i) b_d[wr_addr_i] = wr_data_i;
          else          a_d[wr_addr_i] = wr_data_i;
        end
        if (start_i) begin
          state_d  = STREAM;
          t_d      = '0;
          slot_sel = '0;
          emit     = 1'b1;
        end
      end
      STREAM: begin
        if (t_q == LAST) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d      = t_q + TW'(1);
          slot_sel = t_q + TW'(1);
          emit     = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slot t puts A[r][t-r] on row r and B[t-c][c] on column c; k is the diagonal offset.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      left_d[r] = '0;
      up_d[r]   = '0;
    end
    if (emit) begin
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 4; k++) begin
          if (int'(slot_sel) == r + k) begin
            left_d[r] = a_d[4'(4 * r + k)];
            up_d[r]   = b_d[4'(4 * k + r)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      for (int r = 0; r < 4; r++) begin
        left_q[r] <= '0;
        up_q[r]   <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int i = 0; i < 16; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
      end
      for (int r = 0; r < 4; r++) begin
        left_q[r] <= left_d[r];
        up_q[r]   <= up_d[r];
      end
    end
  end

  assign left_o_0  = left_q[0];
  assign left_o_4  = left_q[1];
  assign left_o_8  = left_q[2];
  assign left_o_12 = left_q[3];
  assign up_o_0    = up_q[0];
  assign up_o_1    = up_q[1];
  assign up_o_2    = up_q[2];
  assign up_o_3    = up_q[3];

  assign valid_o = (state_q == STREAM);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a FLUSH=3 and a FLUSH=0 instance share one stimulus stream
// and are compared against an index-formula model of the skewed edge feed.
module tb_systolic_skew_feeder;

  localparam int DW = 32;
  localparam int LA = 10;
  localparam int LB = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, wr_sel, start;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] la [4];
  logic [DW-1:0] ua [4];
  logic [DW-1:0] lb [4];
  logic [DW-1:0] ub [4];
  logic valid_a, busy_a, done_a, valid_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ma [16];
  logic [DW-1:0] mb [16];

  typedef struct {
    int l0, l1, l2, l3;
    int u0, u1, u2, u3;
  } vec_t;
  vec_t tbl [LA];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .FLUSH(3)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .start_i(start),
    .left_o_0(la[0]), .left_o_4(la[1]), .left_o_8(la[2]), .left_o_12(la[3]),
    .up_o_0(ua[0]), .up_o_1(ua[1]), .up_o_2(ua[2]), .up_o_3(ua[3]),
    .valid_o(valid_a), .busy_o(busy_a), .done_o(done_a)
  );

  systolic_skew_feeder #(.DATA_WIDTH(DW), .FLUSH(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .start_i(start),
    .left_o_0(lb[0]), .left_o_4(lb[1]), .left_o_8(lb[2]), .left_o_12(lb[3]),
    .up_o_0(ub[0]), .up_o_1(ub[1]), .up_o_2(ub[2]), .up_o_3(ub[3]),
    .valid_o(valid_b), .busy_o(busy_b), .done_o(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_left(input int r, input int t);
    int k = t - r;
    if (k >= 0 && k <= 3) return ma[r * 4 + k];
    return '0;
  endfunction

  function automatic logic [DW-1:0] m_up(input int c, input int t);
    int k = t - c;
    if (k >= 0 && k <= 3) return mb[k * 4 + c];
    return '0;
  endfunction

  function automatic int tbl_left(input int r, input int t);
    case (r)
      0: return tbl[t].l0;
      1: return tbl[t].l1;
      2: return tbl[t].l2;
      default: return tbl[t].l3;
    endcase
  endfunction

  function automatic int tbl_up(input int c, input int t);
    case (c)
      0: return tbl[t].u0;
      1: return tbl[t].u1;
      2: return tbl[t].u2;
      default: return tbl[t].u3;
    endcase
  endfunction

  task automatic write_elem(input logic sel, input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    if (sel) mb[addr] = data;
    else     ma[addr] = data;
  endtask

  task automatic check_b(input int t);
    if (t < LB) begin
      chk($sformatf("b_valid_t%0d", t), valid_b, 1);
      for (int r = 0; r < 4; r++) begin
        chk($sformatf("b_left%0d_t%0d", r, t), lb[r], m_left(r, t));
        chk($sformatf("b_up%0d_t%0d", r, t), ub[r], m_up(r, t));
      end
    end else if (t == LB) begin
      chk("b_done_after_slot6", done_b, 1);
      chk("b_valid_in_done", valid_b, 0);
      for (int r = 0; r < 4; r++) chk($sformatf("b_left%0d_in_done", r), lb[r], 0);
    end else if (t == LB + 1) begin
      chk("b_done_single_cycle", done_b, 0);
      chk("b_busy_idle", busy_b, 0);
    end
  endtask

  // One stream on both instances; optionally inject ignored inputs or a reset at a slot.
  task automatic run_stream(input bit use_tbl, input int inj_t, input int rst_t);
    int dones = 0;
    logic [DW-1:0] el, eu;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int t = 0; t < LA; t++) begin
      if (done_a) dones++;
      chk($sformatf("a_valid_t%0d", t), valid_a, 1);
      chk($sformatf("a_busy_t%0d", t), busy_a, 1);
      for (int r = 0; r < 4; r++) begin
        el = use_tbl ? DW'(tbl_left(r, t)) : m_left(r, t);
        eu = use_tbl ? DW'(tbl_up(r, t))   : m_up(r, t);
        chk($sformatf("a_left%0d_t%0d", r, t), la[r], el);
        chk($sformatf("a_up%0d_t%0d", r, t), ua[r], eu);
      end
      check_b(t);
      if (t == rst_t) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_valid_a", valid_a, 0);
        chk("rst_mid_busy_a", busy_a, 0);
        chk("rst_mid_valid_b", valid_b, 0);
        chk("rst_mid_busy_b", busy_b, 0);
        for (int r = 0; r < 4; r++) begin
          chk($sformatf("rst_mid_left%0d", r), la[r], 0);
          chk($sformatf("rst_mid_up%0d", r), ua[r], 0);
          chk($sformatf("rst_mid_b_left%0d", r), lb[r], 0);
        end
        dones = 0;
        for (int k = 0; k < LA + 2; k++) begin
          if (done_a || done_b) dones++;
          tick();
        end
        chk("rst_mid_no_done", dones, 0);
        for (int i = 0; i < 16; i++) begin
          ma[i] = '0;
          mb[i] = '0;
        end
        return;
      end
      if (t == inj_t) begin
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = 4'd0;
        wr_data = 99;
        start   = 1'b1;
      end
      tick();
      wr_en = 1'b0;
      start = 1'b0;
    end
    if (done_a) dones++;
    chk("a_done_pulse", done_a, 1);
    chk("a_valid_in_done", valid_a, 0);
    chk("a_busy_in_done", busy_a, 1);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("a_left%0d_in_done", r), la[r], 0);
      chk($sformatf("a_up%0d_in_done", r), ua[r], 0);
    end
    tick();
    chk("a_done_single_cycle", done_a, 0);
    chk("a_busy_idle", busy_a, 0);
    chk("a_one_done_per_start", dones, 1);
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 0,  1, 0, 0, 0};
    tbl[1] = '{2, 5, 0, 0,  1, 2, 0, 0};
    tbl[2] = '{3, 6, 9, 0,  1, 2, 3, 0};
    tbl[3] = '{4, 7, 10, 13, 1, 2, 3, 4};
    tbl[4] = '{0, 8, 11, 14, 0, 2, 3, 4};
    tbl[5] = '{0, 0, 12, 15, 0, 0, 3, 4};
    tbl[6] = '{0, 0, 0, 16,  0, 0, 0, 4};
    for (int t = 7; t < LA; t++) tbl[t] = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end

    rst_n = 1'b0; start = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    tick();
    tick();
    chk("rst_valid_a", valid_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_busy_b", busy_b, 0);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("rst_left%0d", r), la[r], 0);
      chk($sformatf("rst_up%0d", r), ua[r], 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_stream", busy_a, 0);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        write_elem(1'b0, r * 4 + c, DW'(4 * r + c + 1));
        write_elem(1'b1, r * 4 + c, DW'(c + 1));
      end
    run_stream(1'b1, -1, -1);
    run_stream(1'b1, 2, -1);
    run_stream(1'b1, -1, -1);

    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) begin
        write_elem(1'b0, i, $urandom());
        write_elem(1'b1, i, $urandom());
      end
      run_stream(1'b0, -1, -1);
    end

    // write and start on the same edge: slot 0 must see the new A[0][0]
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = $urandom();
    ma[0] = wr_data;
    run_stream(1'b0, -1, -1);

    // start held high: restart only after DONE -> IDLE, period L+2
    start = 1'b1;
    tick();
    for (int k = 0; k < 2 * (LA + 2); k++) begin
      chk($sformatf("hold_a_valid_k%0d", k), valid_a, DW'((k % (LA + 2)) < LA));
      chk($sformatf("hold_b_valid_k%0d", k), valid_b, DW'((k % (LB + 2)) < LB));
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < LA + 2; k++) tick();
    chk("hold_a_idle", busy_a, 0);
    chk("hold_b_idle", busy_b, 0);

    run_stream(1'b0, -1, 4);
    run_stream(1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
